// File: rtl/rtc_timer_10ms.sv
// Base time reference for the stopwatch: square wave inverted every TOGGLE_COUNT
// enabled clocks, plus a one-cycle strobe marking each inversion.
module rtc_timer_10ms #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TOGGLE_MS    = 10,
  parameter int TOGGLE_COUNT = CLK_FREQ_HZ / 1000 * TOGGLE_MS,
  localparam int CNT_W       = (TOGGLE_COUNT > 1) ? $clog2(TOGGLE_COUNT) : 1
) (
  input  logic i_sclk,
  input  logic i_reset,
  input  logic i_timerenb,
  output logic o_base_tick,
  output logic o_tick_pulse
);

  generate
    if (TOGGLE_COUNT < 1) begin : g_bad_count
      $error("rtc_timer_10ms: TOGGLE_COUNT must be >= 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TOGGLE_COUNT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;
  logic             pulse_q;
  logic             pulse_d;

  // A paused counter keeps its partial count so every inversion costs exactly TOGGLE_COUNT enabled edges.
  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    pulse_d = 1'b0;
    if (i_timerenb) begin
      if (cnt_q == TERM_CNT) begin
        cnt_d   = {CNT_W{1'b0}};
        tick_d  = ~tick_q;
        pulse_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        tick_d  = tick_q;
        pulse_d = 1'b0;
      end
    end else begin
      cnt_d   = cnt_q;
      tick_d  = tick_q;
      pulse_d = 1'b0;
    end
  end

  // State registers; reset overrides enable.
  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      tick_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_base_tick  = tick_q;
  assign o_tick_pulse = pulse_q;

endmodule

// File: tb/tb_rtc_timer_10ms.sv
// Randomized bench for rtc_timer_10ms: several divider sizes run side by side
// against a model counting enabled edges since reset.
module tb_rtc_timer_10ms;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [NI-1:0] tick_s;
  logic [NI-1:0] pulse_s;

  longint e_cnt [NI];
  logic   exp_pulse [NI];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rtc_timer_10ms #(.TOGGLE_COUNT(5)) u_n5 (
    .i_sclk(clk), .i_reset(rst), .i_timerenb(en),
    .o_base_tick(tick_s[0]), .o_tick_pulse(pulse_s[0]));
  rtc_timer_10ms #(.TOGGLE_COUNT(1)) u_n1 (
    .i_sclk(clk), .i_reset(rst), .i_timerenb(en),
    .o_base_tick(tick_s[1]), .o_tick_pulse(pulse_s[1]));
  rtc_timer_10ms #(.TOGGLE_COUNT(4)) u_n4 (
    .i_sclk(clk), .i_reset(rst), .i_timerenb(en),
    .o_base_tick(tick_s[2]), .o_tick_pulse(pulse_s[2]));
  rtc_timer_10ms #(.CLK_FREQ_HZ(100_000), .TOGGLE_MS(10)) u_n1000 (
    .i_sclk(clk), .i_reset(rst), .i_timerenb(en),
    .o_base_tick(tick_s[3]), .o_tick_pulse(pulse_s[3]));
  rtc_timer_10ms u_default (
    .i_sclk(clk), .i_reset(rst), .i_timerenb(en),
    .o_base_tick(tick_s[4]), .o_tick_pulse(pulse_s[4]));

  function automatic longint n_of(input int k);
    case (k)
      0:       n_of = 5;
      1:       n_of = 1;
      2:       n_of = 4;
      3:       n_of = 1000;
      default: n_of = 1000000;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 ns later.
  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en  = e;
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (r) begin
        e_cnt[k]     = 0;
        exp_pulse[k] = 1'b0;
      end else if (e) begin
        e_cnt[k]     = e_cnt[k] + 1;
        exp_pulse[k] = ((e_cnt[k] % n_of(k)) == 0);
      end else begin
        exp_pulse[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("tick_n%0d", n_of(k)), {31'd0, tick_s[k]},
               32'((e_cnt[k] / n_of(k)) % 2));
      check_eq($sformatf("pulse_n%0d", n_of(k)), {31'd0, pulse_s[k]},
               {31'd0, exp_pulse[k]});
    end
  endtask

  initial begin
    int inv;
    int last_pulse;
    rst = 1'b1;
    en  = 1'b1;
    for (int k = 0; k < NI; k++) begin
      e_cnt[k]     = 0;
      exp_pulse[k] = 1'b0;
    end

    // Reset held with enable high: outputs stay low.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_eq("reset_tick", {31'd0, tick_s[0]}, 32'd0);
    check_eq("reset_pulse_n1", {31'd0, pulse_s[1]}, 32'd0);

    // First inversions with enable held high.
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      if (i == 4)  check_eq("t1_before_rise", {31'd0, tick_s[0]}, 32'd0);
      if (i == 5)  check_eq("t1_rise", {31'd0, tick_s[0]}, 32'd1);
      if (i == 5)  check_eq("t1_rise_pulse", {31'd0, pulse_s[0]}, 32'd1);
      if (i == 6)  check_eq("t1_pulse_one_cycle", {31'd0, pulse_s[0]}, 32'd0);
      if (i == 10) check_eq("t1_fall", {31'd0, tick_s[0]}, 32'd0);
    end

    // Pause for 7 cycles after 3 enabled edges.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    check_eq("t2_hold", {31'd0, tick_s[0]}, 32'd0);
    step(1'b0, 1'b1);
    check_eq("t2_no_early", {31'd0, tick_s[0]}, 32'd0);
    step(1'b0, 1'b1);
    check_eq("t2_resume_rise", {31'd0, tick_s[0]}, 32'd1);

    // Enable dropping on the terminal-count cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("t_term_drop", {31'd0, tick_s[0]}, 32'd1);
    step(1'b0, 1'b1);
    check_eq("t_term_resume", {31'd0, tick_s[0]}, 32'd0);

    // Reset mid-count with tick high and count 3.
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check_eq("t3_pre_tick", {31'd0, tick_s[0]}, 32'd1);
    step(1'b1, 1'b1);
    check_eq("t3_reset_tick", {31'd0, tick_s[0]}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check_eq("t3_no_memory", {31'd0, tick_s[0]}, 32'd0);
    step(1'b0, 1'b1);
    check_eq("t3_fresh_rise", {31'd0, tick_s[0]}, 32'd1);

    // Randomized enable with occasional reset.
    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));
    end

    // Long enabled run: inversions of the 1000-cycle divider are evenly spaced.
    step(1'b1, 1'b0);
    inv        = 0;
    last_pulse = 0;
    for (int i = 1; i <= 6000; i++) begin
      step(1'b0, 1'b1);
      if (pulse_s[3] === 1'b1) begin
        inv++;
        check_eq("spacing_n1000", 32'(i - last_pulse), 32'd1000);
        last_pulse = i;
      end
    end
    check_eq("inv_count_n1000", 32'(inv), 32'd6);
    check_eq("default_no_toggle", {31'd0, tick_s[4]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_timer_10ms.md
Name: rtc_timer_10ms

Overview:
- Base time-reference generator for the stopwatch.
- Divides the system clock down and inverts a square-wave tick every 10 ms; default assumes a 100 MHz board clock.
- Also emits a one-cycle strobe at each inversion for downstream BCD time counters.
- Counting can be paused or resumed with an enable input without losing the partial count.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
- TOGGLE_MS, 10, interval in milliseconds between successive o_base_tick inversions.
- TOGGLE_COUNT, CLK_FREQ_HZ/1000*TOGGLE_MS (1_000_000), enabled clock cycles per inversion. Overridable for simulation; must be >= 1, and elaboration fails otherwise.
- CNT_W, $clog2(TOGGLE_COUNT) (min 1), internal counter width (derived; do not override).

Ports:
- i_sclk  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_timerenb  input  1  count enable; high = run, low = freeze counter and outputs.
- o_base_tick  output  1  square wave, inverted every TOGGLE_COUNT enabled cycles (default 20 ms period, 50% duty).
- o_tick_pulse  output  1  one-cycle strobe, high in the cycle in which o_base_tick shows its new value.

Behaviour:
- Single clock domain, fully synchronous; all outputs are registered.
- Reset: sampled on the rising edge of i_sclk; on the edge where i_reset=1, the counter goes to 0, o_base_tick=0 and o_tick_pulse=0. Reset has priority over i_timerenb.
- Reset asserted mid-count discards the partial count; there is no memory of the previous phase.
- Enabled, counter < TOGGLE_COUNT-1: counter increments by 1; o_tick_pulse=0.
- Enabled, counter == TOGGLE_COUNT-1: counter wraps to 0; o_base_tick inverts; o_tick_pulse=1 for that next cycle only.
- Disabled (i_timerenb=0): counter and o_base_tick hold their values; o_tick_pulse=0.
- Resuming after a pause continues from the held count, so total enabled cycles between inversions is always exactly TOGGLE_COUNT.
- First inversion after reset release with enable held high: o_base_tick goes 0->1 after the TOGGLE_COUNT-th enabled rising edge.
- Enable dropping exactly on the terminal-count cycle: no inversion occurs; the inversion happens on the first enabled edge after resume.
- TOGGLE_COUNT=1: o_base_tick inverts on every enabled edge, and o_tick_pulse stays high continuously while enabled.
- Counter never exceeds TOGGLE_COUNT-1; no overflow state exists.
- Output values while reset is held: o_base_tick=0, o_tick_pulse=0.
- No combinational path from inputs to outputs.

Test Plan:
1. TOGGLE_COUNT=5, 10 ns clock, i_reset=1 for 2 cycles, then i_reset=0 with i_timerenb=1 -> o_base_tick=0 through the first 4 enabled edges; becomes 1 after the 5th edge; becomes 0 after the 10th; o_tick_pulse high for exactly one cycle at each change.
2. Pause: TOGGLE_COUNT=5, enable for 3 edges, i_timerenb=0 for 7 cycles, then re-enable -> no change while disabled; o_base_tick inverts after 2 further enabled edges.
3. Reset mid-count: TOGGLE_COUNT=5, o_base_tick=1 and counter=3, assert i_reset for 1 cycle -> o_base_tick=0 next edge; next inversion requires 5 fresh enabled edges.
4. Reset with i_timerenb=1 held throughout -> outputs stay 0 while reset is high (reset wins).
5. TOGGLE_COUNT=1 with enable high -> o_base_tick toggles every cycle and o_tick_pulse is constantly 1; drop enable -> both freeze / pulse=0.
6. Defaults (100 MHz, 10 ms), enabled 2,000,000 cycles -> exactly 2 inversions, spaced 1,000,000 cycles (10 ms) apart; o_base_tick period = 20 ms.
